// File: rtl/stage4_mem.sv
// MEM stage of the RV64 pipeline: EX/MEM register, branch resolution, data-memory req/ack
// handshake with upstream stall, and the MEM/WB register. Optional ack watchdog: MEM_TIMEOUT_EN.
module stage4_mem #(
  parameter int N              = 64,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic [N-1:0]     ex_sum,
  input  logic             ex_zero,
  input  logic [N-1:0]     ex_alu_result,
  input  logic [N-1:0]     ex_read_data2,
  input  logic [4:0]       ex_write_register,
  input  logic             ex_MemToReg,
  input  logic             ex_RegWrite,
  input  logic             ex_MemRead,
  input  logic             ex_MemWrite,
  input  logic             ex_Branch,
  output logic             stall,
  output logic             pc_src,
  output logic [N-1:0]     branch_target,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic             wb_valid,
  output logic [N-1:0]     wb_read_data,
  output logic [N-1:0]     wb_alu_result,
  output logic [4:0]       wb_write_register,
  output logic             wb_MemToReg,
  output logic             wb_RegWrite,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_error
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state_q;

  logic         exm_valid_q;
  logic [N-1:0] exm_sum_q;
  logic         exm_zero_q;
  logic [N-1:0] exm_alu_result_q;
  logic [N-1:0] exm_read_data2_q;
  logic [4:0]   exm_write_register_q;
  logic         exm_MemToReg_q;
  logic         exm_RegWrite_q;
  logic         exm_MemRead_q;
  logic         exm_MemWrite_q;
  logic         exm_Branch_q;

  logic         wb_valid_q;
  logic [N-1:0] wb_read_data_q;
  logic [N-1:0] wb_alu_result_q;
  logic [4:0]   wb_write_register_q;
  logic         wb_MemToReg_q;
  logic         wb_RegWrite_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic         timeout;
  logic         is_load;
  logic [N-1:0] wb_read_data_d;

  assign mem_req   = exm_valid_q & (exm_MemRead_q | exm_MemWrite_q);
  assign mem_we    = exm_MemWrite_q;
  assign mem_addr  = exm_alu_result_q;
  assign mem_wdata = exm_read_data2_q;

  // An aborted access behaves like an ack, so it also releases the stall.
  assign stall = mem_req & ~(mem_ack | timeout);

  assign pc_src        = exm_valid_q & exm_Branch_q & exm_zero_q;
  assign branch_target = exm_sum_q;

  // A simultaneous read+write is a store and returns no load data.
  assign is_load        = exm_valid_q & exm_MemRead_q & ~exm_MemWrite_q;
  assign wb_read_data_d = (is_load & ~timeout) ? mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       mem_error_q;

  assign timeout   = (state_q == WAIT) && (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign mem_error = mem_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      mem_error_q <= 1'b0;
    end else begin
      if (state_q == WAIT && !mem_ack && !timeout) to_cnt_q <= to_cnt_q + 8'd1;
      else                                         to_cnt_q <= '0;
      if (timeout) mem_error_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout              = 1'b0;
  assign mem_error            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (mem_req && !mem_ack) state_q <= WAIT;
        WAIT:    if (mem_ack || timeout)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid_q          <= 1'b0;
      exm_sum_q            <= '0;
      exm_zero_q           <= 1'b0;
      exm_alu_result_q     <= '0;
      exm_read_data2_q     <= '0;
      exm_write_register_q <= '0;
      exm_MemToReg_q       <= 1'b0;
      exm_RegWrite_q       <= 1'b0;
      exm_MemRead_q        <= 1'b0;
      exm_MemWrite_q       <= 1'b0;
      exm_Branch_q         <= 1'b0;
    end else if (!stall) begin
      if (ex_valid && !ex_flush) begin
        exm_valid_q          <= 1'b1;
        exm_sum_q            <= ex_sum;
        exm_zero_q           <= ex_zero;
        exm_alu_result_q     <= ex_alu_result;
        exm_read_data2_q     <= ex_read_data2;
        exm_write_register_q <= ex_write_register;
        exm_MemToReg_q       <= ex_MemToReg;
        exm_RegWrite_q       <= ex_RegWrite;
        exm_MemRead_q        <= ex_MemRead;
        exm_MemWrite_q       <= ex_MemWrite;
        exm_Branch_q         <= ex_Branch;
      end else begin
        exm_valid_q          <= 1'b0;
        exm_sum_q            <= '0;
        exm_zero_q           <= 1'b0;
        exm_alu_result_q     <= '0;
        exm_read_data2_q     <= '0;
        exm_write_register_q <= '0;
        exm_MemToReg_q       <= 1'b0;
        exm_RegWrite_q       <= 1'b0;
        exm_MemRead_q        <= 1'b0;
        exm_MemWrite_q       <= 1'b0;
        exm_Branch_q         <= 1'b0;
      end
    end
  end

  // While stalled only the control bits become a bubble; data fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q          <= 1'b0;
      wb_read_data_q      <= '0;
      wb_alu_result_q     <= '0;
      wb_write_register_q <= '0;
      wb_MemToReg_q       <= 1'b0;
      wb_RegWrite_q       <= 1'b0;
    end else if (stall) begin
      wb_valid_q    <= 1'b0;
      wb_MemToReg_q <= 1'b0;
      wb_RegWrite_q <= 1'b0;
    end else begin
      wb_valid_q          <= exm_valid_q;
      wb_read_data_q      <= wb_read_data_d;
      wb_alu_result_q     <= exm_alu_result_q;
      wb_write_register_q <= exm_write_register_q;
      wb_MemToReg_q       <= exm_MemToReg_q;
      wb_RegWrite_q       <= exm_RegWrite_q & exm_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, stall};
  end

  assign wb_valid          = wb_valid_q;
  assign wb_read_data      = wb_read_data_q;
  assign wb_alu_result     = wb_alu_result_q;
  assign wb_write_register = wb_write_register_q;
  assign wb_MemToReg       = wb_MemToReg_q;
  assign wb_RegWrite       = wb_RegWrite_q;
  assign stall_cycles      = stall_cycles_q;

endmodule
